// File: rtl/kgp_fetch_pkg.sv
// Shared types and default widths for the instruction fetch stage.
package kgp_fetch_pkg;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_INSTR_W = 32;
  localparam int DEF_DEPTH   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0]  pc;
    logic [DEF_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO holding fetched {pc, instr} words between memory and decode.
// clear empties it on the same edge and takes priority over push and pop.
module fetch_buffer #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  logic [WIDTH-1:0]       push_data,
  output logic [$clog2(DEPTH):0] count,
  output logic [WIDTH-1:0]       head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL) || do_pop);
  assign head    = mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; an entry is only visible once count covers it.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one outstanding imem request, buffered {pc, instr} handed to decode.
// Define FETCH_PERF_EN to add the perf_fetched / perf_stall saturating counters.
module instr_fetch_unit
  import kgp_fetch_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int DEPTH   = DEF_DEPTH
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc,
  output logic               pc_advance,
  input  logic               flush,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [INSTR_W-1:0] if_instr,
  input  logic               id_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stall
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = ADDR_W + INSTR_W;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  fetch_state_t      state;
  fetch_state_t      state_nxt;
  logic [ADDR_W-1:0] req_pc;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_after;
  logic [ENT_W-1:0]  head;
  logic              push;
  logic              pop;

  assign if_valid  = (count != '0);
  assign pop       = if_valid && id_ready;
  assign imem_addr = pc;
  assign if_pc     = if_valid ? head[ENT_W-1:INSTR_W] : '0;
  assign if_instr  = if_valid ? head[INSTR_W-1:0]     : '0;

  // Occupancy after a push in WAIT, including a same-cycle pop by decode.
  assign count_after = count + CNT_W'(1) - CNT_W'(pop);

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clock) begin
    if (!reset)                          req_pc <= '0;
    else if (state == REQ && imem_gnt)   req_pc <= pc;
  end

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt  = state;
    imem_req   = 1'b0;
    pc_advance = 1'b0;
    push       = 1'b0;
    case (state)
      IDLE: begin
        if (!flush && count < DEPTH_C) state_nxt = REQ;
      end
      REQ: begin
        imem_req = 1'b1;
        if (imem_gnt) begin
          pc_advance = !flush;
          state_nxt  = flush ? DROP : WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          push      = !flush;
          state_nxt = (!flush && count_after < DEPTH_C) ? REQ : IDLE;
        end else if (flush) begin
          state_nxt = DROP;
        end
      end
      DROP: begin
        // The granted word is wrong-path; swallow it whenever it arrives.
        if (imem_rvalid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  fetch_buffer #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_buffer (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .clear     (flush),
    .push_data ({req_pc, imem_rdata}),
    .count     (count),
    .head      (head)
  );

`ifdef FETCH_PERF_EN
  logic stall_cycle;

  assign stall_cycle = (imem_req && !imem_gnt) || (state == IDLE && count == DEPTH_C);

  always_ff @(posedge clock) begin
    if (!reset) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (push && perf_fetched != '1)      perf_fetched <= perf_fetched + 32'd1;
      if (stall_cycle && perf_stall != '1) perf_stall   <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: PC register + memory model + FIFO scoreboard.
module tb_instr_fetch_unit;
  import kgp_fetch_pkg::*;

  localparam int DEPTH = 2;

  logic        clock;
  logic        reset;
  logic [31:0] pc;
  logic        pc_advance;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        id_ready;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  instr_fetch_unit #(
    .ADDR_W  (32),
    .INSTR_W (32),
    .DEPTH   (DEPTH)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .pc          (pc),
    .pc_advance  (pc_advance),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .id_ready    (id_ready)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish, got timeout required finish");
    $fatal(1);
  end

  int vectors;
  int miscompares;

  // Memory model: at most one owed response, latency counted in cycles after the grant.
  bit          pend;
  logic [31:0] pend_addr;
  int          pend_lat;
  bit          pend_kill;
  int          gnt_pct;
  int          lat_min;
  int          lat_max;
  bit          use_override;
  logic [31:0] override_word;

  // Reference fetch buffer and stream bookkeeping.
  fetch_entry_t mq[$];
  logic [31:0]  exp_pc;
  logic [31:0]  exp_fetched;
  logic [31:0]  exp_stall;
  int           delivered;
  int           n_gnt;
  int           n_adv;
  int           cyc;
  int           first_gnt;
  int           first_valid;
  logic         s_req;
  logic         s_gnt;
  logic         s_adv;
  logic         s_valid;
  logic [31:0]  s_addr;
  logic [31:0]  last_gnt_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic step(input bit fl, input logic [31:0] tgt, input bit rdy);
    logic [31:0]  pc_n;
    fetch_entry_t e;
    bit           had_pend;
    flush       = fl;
    id_ready    = rdy;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    had_pend    = pend;
    if (pend && pend_lat == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = use_override ? override_word : mem_word(pend_addr);
    end
    #1;
    imem_gnt = imem_req && ($urandom_range(99) < gnt_pct);
    #1;
    s_req   = imem_req;
    s_gnt   = imem_gnt;
    s_adv   = pc_advance;
    s_valid = if_valid;
    s_addr  = imem_addr;

    check("adv", pc_advance, imem_req & imem_gnt & ~fl);
    if (imem_req) check("addr", imem_addr, pc);
    if (had_pend) check("one_outstanding", imem_req, 0);
    check("valid", if_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      check("head_pc", if_pc, mq[0].pc);
      check("head_instr", if_instr, mq[0].instr);
    end
`ifdef FETCH_PERF_EN
    check("perf_fetched", perf_fetched, exp_fetched);
    check("perf_stall", perf_stall, exp_stall);
    if ((imem_req && !imem_gnt) || (!imem_req && !had_pend && mq.size() == DEPTH)) exp_stall++;
`endif
    if (first_gnt < 0 && imem_req && imem_gnt) first_gnt = cyc;
    if (first_valid < 0 && if_valid) first_valid = cyc;
    if (pc_advance) n_adv++;

    if (fl) begin
      mq.delete();
      exp_pc = tgt;
      if (pend) pend_kill = 1'b1;
    end else begin
      if (mq.size() != 0 && rdy) begin
        check("seq", if_pc, exp_pc);
        exp_pc++;
        void'(mq.pop_front());
        delivered++;
      end
      if (imem_rvalid && !pend_kill) begin
        e.pc    = pend_addr;
        e.instr = imem_rdata;
        mq.push_back(e);
        exp_fetched++;
        check("room", mq.size() <= DEPTH, 1);
      end
    end

    if (imem_rvalid) pend = 1'b0;
    if (imem_req && imem_gnt) begin
      pend          = 1'b1;
      pend_addr     = imem_addr;
      pend_kill     = fl;
      pend_lat      = int'($urandom_range(lat_max, lat_min)) - 1;
      last_gnt_addr = imem_addr;
      n_gnt++;
    end else if (pend) begin
      pend_lat--;
    end

    pc_n = fl ? tgt : (pc_advance ? pc + 32'd1 : pc);
    cyc++;
    @(posedge clock);
    #1 pc = pc_n;
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    flush       = 1'b0;
    id_ready    = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    pc          = '0;
    pend        = 1'b0;
    pend_kill   = 1'b0;
    mq.delete();
    exp_pc      = '0;
    exp_fetched = '0;
    exp_stall   = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      imem_rvalid = (i % 2 == 1);
      imem_rdata  = 32'hBAD0_0000 + 32'(i);
      #1;
      check("rst_req", imem_req, 0);
      check("rst_adv", pc_advance, 0);
      check("rst_valid", if_valid, 0);
      check("rst_pc", if_pc, 0);
      check("rst_instr", if_instr, 0);
`ifdef FETCH_PERF_EN
      check("rst_perf_fetched", perf_fetched, 0);
      check("rst_perf_stall", perf_stall, 0);
`endif
    end
    reset       = 1'b1;
    imem_rvalid = 1'b0;
    @(negedge clock);
    #1;
    check("release_req", imem_req, 1);
    check("release_addr", imem_addr, 0);
  endtask

  initial begin
    int          d0;
    int          g0;
    int          a0;
    int          stall_seen;
    bit          got;
    bit          found;
    bit          fl;
    logic [31:0] tgt;
    logic [31:0] f0;

    vectors       = 0;
    miscompares   = 0;
    gnt_pct       = 100;
    lat_min       = 1;
    lat_max       = 1;
    use_override  = 1'b0;
    override_word = '0;
    delivered     = 0;
    n_gnt         = 0;
    n_adv         = 0;
    cyc           = 0;
    first_gnt     = -1;
    first_valid   = -1;

    do_reset();

    // Single-cycle memory, decode always ready: words 0,1,2 in order.
    for (int i = 0; i < 8; i++) step(0, '0, 1);
    check("first_valid_latency", first_valid - first_gnt, 2);
    check("delivered_0_1_2", delivered, 3);
    check("adv_per_gnt", n_adv, n_gnt);

    // Back-pressure: buffer fills to DEPTH, then fetch stops.
    for (int i = 0; i < 12; i++) step(0, '0, 0);
    check("bp_req", s_req, 0);
    check("bp_adv", s_adv, 0);
    check("bp_valid", s_valid, 1);
    check("bp_depth", mq.size(), DEPTH);
    d0 = delivered;
    g0 = n_gnt;
    for (int i = 0; i < 8; i++) step(0, '0, 1);
    check("bp_pops", (delivered - d0) >= 2, 1);
    check("bp_resume", (n_gnt - g0) > 0, 1);

    // Grant withheld for 3 cycles at pc=5.
    step(1, 32'd5, 1);
    gnt_pct    = 0;
    stall_seen = 0;
    a0         = n_adv;
    for (int i = 0; i < 12 && stall_seen < 3; i++) begin
      step(0, '0, 1);
      if (s_req) stall_seen++;
    end
    check("stall_cycles", stall_seen, 3);
    gnt_pct = 100;
    step(0, '0, 1);
    check("stall_gnt_req", s_req, 1);
    check("stall_gnt_addr", s_addr, 32'd5);
    check("stall_adv_once", n_adv - a0, 1);

    // Flush while waiting on pc=7; its 0xDEAD reply must be discarded.
    step(1, 32'd7, 1);
    use_override  = 1'b1;
    override_word = 32'h0000_DEAD;
    lat_min       = 3;
    lat_max       = 3;
    got           = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      step(0, '0, 1);
      got = s_req && s_gnt;
    end
    check("wait_gnt", got, 1);
    check("wait_gnt_addr", last_gnt_addr, 32'd7);
    step(1, 32'h40, 1);
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      step(0, '0, 1);
      got = s_req;
    end
    use_override = 1'b0;
    lat_min      = 1;
    lat_max      = 1;
    check("drop_next_req", got, 1);
    check("drop_next_addr", s_addr, 32'h40);
    check("drop_empty", s_valid, 0);

    // Flush on the same cycle as a response and a pop.
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mq.size() != 0 && pend && pend_lat == 0 && !pend_kill) begin
        found = 1'b1;
        break;
      end
      step(0, '0, 0);
    end
    check("flush_setup", found, 1);
`ifdef FETCH_PERF_EN
    f0 = perf_fetched;
`else
    f0 = '0;
`endif
    step(1, 32'h80, 1);
`ifdef FETCH_PERF_EN
    check("flush_perf_fetched", perf_fetched, f0);
`endif
    step(0, '0, 1);
    check("flush_empty", s_valid, 0);

    // Randomised traffic with redirects, some near the top of the address space.
    gnt_pct = 70;
    lat_min = 1;
    lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      fl  = ($urandom_range(99) < 3);
      tgt = ($urandom_range(3) == 0) ? 32'hFFFF_FFFD : $urandom;
      step(fl, tgt, $urandom_range(99) < 75);
    end
    check("progress", delivered > 200, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly downstream of the Program_Counter register; consumes its current PC and reads the word from instruction memory.
- Uses a request/grant/response handshake to instruction memory, with at most one request outstanding.
- Holds fetched {pc, instr} pairs in a small FIFO and hands them to decode with valid/ready.
- Tells the PC register when to advance (load pc+1; word-addressed) and discards wrong-path words on flush.

Parameters:
- ADDR_W, 32, PC / instruction-memory address width
- INSTR_W, 32, instruction word width
- DEPTH, 2, fetch buffer entries (power of 2, >=2)

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset (sampled on rising edge of clock)
- pc  in  ADDR_W  current PC from Program_Counter pc_out
- pc_advance  out  1  PC register loads pc+1 this edge
- flush  in  1  redirect (branch/jump); PC is rewritten externally same edge
- imem_req  out  1  instruction-memory request valid
- imem_addr  out  ADDR_W  request address
- imem_gnt  in  1  memory accepts request this cycle
- imem_rvalid  in  1  response word valid
- imem_rdata  in  INSTR_W  response word
- if_valid  out  1  buffer head valid to decode
- if_pc  out  ADDR_W  head PC
- if_instr  out  INSTR_W  head instruction
- id_ready  in  1  decode accepts head this cycle

Behaviour:
- Reset (reset==0 at edge):
  - FSM to IDLE; buffer emptied.
  - imem_req=0, pc_advance=0, if_valid=0, if_pc=0, if_instr=0.
  - Reset mid-transaction abandons it; a later imem_rvalid is ignored until a new request is granted.
- FSM states:
  - IDLE:
    - imem_req=0.
    - Go to REQ when !flush and (count + 0) < DEPTH, i.e. a slot exists for the response.
  - REQ:
    - imem_req=1, imem_addr=pc (combinational from pc).
    - On imem_gnt: pc_advance=1 that cycle (combinational: pc_advance = REQ & imem_gnt & !flush); capture pc into req_pc; go to WAIT.
    - flush with no gnt: stay in REQ (the new pc is presented next cycle).
    - flush with gnt: pc_advance=0; go to DROP.
  - WAIT:
    - imem_req=0.
    - On imem_rvalid & !flush: push {req_pc, imem_rdata}; go to REQ if a slot remains after the push (accounting for a same-cycle pop), else IDLE.
    - flush without rvalid: go to DROP.
    - flush with rvalid: discard the word; go to IDLE.
  - DROP:
    - Wait for imem_rvalid, discard the word, go to IDLE.
    - Further flush in DROP: stay in DROP.
- Buffer:
  - FIFO of DEPTH entries.
  - Head drives if_pc/if_instr; if_valid = count!=0.
  - Pop on if_valid & id_ready.
  - Push and pop in the same cycle leaves count unchanged.
  - Request issue requires count - pop < DEPTH, so no response is ever dropped for lack of space.
- flush:
  - Clears the buffer the same edge (count=0); if_valid=0 the next cycle.
  - Overrides any same-cycle push or pop.
- Latency: gnt at cycle N with rvalid at N+1 gives if_valid at N+2.
- Steady-state throughput is 1 instruction per 2 cycles with single-cycle memory (one outstanding request).
- Back-pressure: with id_ready=0 the buffer fills to DEPTH, then the FSM holds IDLE and pc_advance stays 0.
- Wrap-around: pc=all-ones is fetched normally; the advance wraps in the PC register, not here.
- Word-addressed; no alignment checks.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - Adds outputs perf_fetched[31:0] (words pushed) and perf_stall[31:0] (cycles with imem_req=1 & !imem_gnt, plus cycles in IDLE blocked by a full buffer).
  - Both counters reset to 0 and saturate at all-ones.
  - Dropped words are not counted.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package kgp_fetch_pkg holds:
  - FSM state typedef {IDLE, REQ, WAIT, DROP} (2-bit encoding 0..3)
  - default ADDR_W/INSTR_W constants
  - fetch-entry struct {pc, instr}
- Sub-module fetch_buffer: parameterised synchronous FIFO (push, pop, clear, count, head) with synchronous active-low reset. The top contains the FSM and glue only.

Test Plan:
- Reset held for 5 cycles with imem_rvalid pulsed -> all outputs 0, no push; release -> imem_req=1, imem_addr=pc=0 the next cycle.
- Single-cycle memory, id_ready=1, pc sequence 0,1,2 -> if_pc/if_instr deliver words for 0,1,2 in order; pc_advance pulses once per gnt; first if_valid 2 cycles after the first gnt.
- id_ready=0 -> exactly 2 entries buffered, imem_req=0, pc_advance=0; raise id_ready -> 2 pops, fetching resumes.
- gnt stalled 3 cycles (imem_req held, imem_addr stable at 5) -> pc_advance only on the gnt cycle.
- flush while in WAIT for pc=7, rvalid 2 cycles later with 0xDEAD -> word discarded, buffer empty, next request uses the new pc=0x40.
- flush coinciding with rvalid and with pop -> buffer count=0, no entry pushed; with FETCH_PERF_EN, perf_fetched is not incremented.
